// File: rtl/sseg_bcd_scan_if.sv
// Display bundle for sseg_bcd_scan: value/dp requests in, scanned digit pins and busy out.
// With SSEG_BLINK_EN defined the bundle also carries the per-digit blink_mask.
interface sseg_bcd_scan_if #(
  parameter int DIGITS = 4,
  parameter int VAL_W  = 14
);
  logic [VAL_W-1:0]  value;
  logic [DIGITS-1:0] dp_in;
  logic [DIGITS-1:0] an;
  logic [6:0]        sseg;
  logic              dp;
  logic              busy;
`ifdef SSEG_BLINK_EN
  logic [DIGITS-1:0] blink_mask;

  modport master (output value, dp_in, blink_mask, input an, sseg, dp, busy);
  modport slave  (input value, dp_in, blink_mask, output an, sseg, dp, busy);
`else
  modport master (output value, dp_in, input an, sseg, dp, busy);
  modport slave  (input value, dp_in, output an, sseg, dp, busy);
`endif
endinterface

// File: rtl/sseg_bcd_scan.sv
// Multiplexed common-anode 7-segment driver with sequential binary-to-BCD conversion.
// Optional digit blinking is compiled in with `define SSEG_BLINK_EN.
//
// state   | meaning
// S_IDLE  | compare value against last converted value, start conversion on change
// S_CONV  | VAL_W shift-add-3 steps on {bcd, bin}
// S_LATCH | copy BCD digits to display regs, update overflow flag
module sseg_bcd_scan #(
  parameter int DIGITS = 4,
  parameter int VAL_W  = 14,
  parameter int DIV_W  = 16,
  parameter int LZB    = 1
`ifdef SSEG_BLINK_EN
  , parameter int BLINK_W = 24
`endif
) (
  input logic            clk,
  input logic            rst,
  sseg_bcd_scan_if.slave bus
);

  // ceil(VAL_W*log10(2) + 1) decimal digits, never fewer than the digits shown
  localparam int BCD_CALC = (VAL_W * 30103 + 199999) / 100000;
  localparam int BCD_N    = (BCD_CALC > DIGITS) ? BCD_CALC : DIGITS;
  localparam int BCD_W    = 4 * BCD_N;
  localparam int CNT_W    = $clog2(VAL_W + 1);
  localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_LATCH} state_t;

  state_t              state;
  logic                start_pending;
  logic [VAL_W-1:0]    last_val;
  logic [VAL_W-1:0]    bin;
  logic [BCD_W-1:0]    bcd;
  logic [BCD_W-1:0]    bcd_adj;
  logic [BCD_W+VAL_W-1:0] sh;
  logic [CNT_W-1:0]    cnt;
  logic                busy_q;
  logic [4*DIGITS-1:0] disp;
  logic                ovf;
  logic                ovf_next;

  logic [DIV_W-1:0]    presc;
  logic [IDX_W-1:0]    idx;
  logic [DIGITS-1:0]   blank;
  logic                zero_run;
  logic [3:0]          cur_nib;
  logic [6:0]          seg_next;
  logic [DIGITS-1:0]   an_next;
  logic                dp_next;
  logic [DIGITS-1:0]   an_q;
  logic [6:0]          sseg_q;
  logic                dp_q;

  function automatic logic [6:0] seg_of(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < BCD_N; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    sh = {bcd_adj, bin} << 1;
  end

  always_comb begin
    ovf_next = 1'b0;
    for (int i = DIGITS; i < BCD_N; i++) begin
      ovf_next = ovf_next | (bcd[4*i +: 4] != 4'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      start_pending <= 1'b1;
      last_val      <= '0;
      bin           <= '0;
      bcd           <= '0;
      cnt           <= '0;
      busy_q        <= 1'b0;
      disp          <= '0;
      ovf           <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_pending || (bus.value != last_val)) begin
            bin           <= bus.value;
            last_val      <= bus.value;
            bcd           <= '0;
            cnt           <= CNT_W'(VAL_W);
            start_pending <= 1'b0;
            busy_q        <= 1'b1;
            state         <= S_CONV;
          end
        end
        S_CONV: begin
          bcd <= sh[BCD_W+VAL_W-1:VAL_W];
          bin <= sh[VAL_W-1:0];
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            busy_q <= 1'b0;
            state  <= S_LATCH;
          end
        end
        S_LATCH: begin
          disp  <= bcd[4*DIGITS-1:0];
          ovf   <= ovf_next;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= presc + 1'b1;
      if (presc == '1) idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

`ifdef SSEG_BLINK_EN
  logic [BLINK_W-1:0] blink_cnt;

  always_ff @(posedge clk) begin
    if (rst) blink_cnt <= '0;
    else     blink_cnt <= blink_cnt + 1'b1;
  end
`endif

  // a digit above 0 is blanked when it and every higher digit are zero
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run & (disp[4*k +: 4] == 4'd0);
      blank[k] = zero_run & (LZB != 0);
    end
  end

  always_comb begin
    cur_nib = disp[{idx, 2'b00} +: 4];
    if (ovf)             seg_next = 7'b0111111;
    else if (blank[idx]) seg_next = 7'b1111111;
    else                 seg_next = seg_of(cur_nib);
    an_next = ~(DIGITS'(1) << idx);
    dp_next = ~bus.dp_in[idx];
`ifdef SSEG_BLINK_EN
    if (blink_cnt[BLINK_W-1] && bus.blink_mask[idx]) begin
      an_next = '1;
      dp_next = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q   <= '1;
      sseg_q <= 7'b1111111;
      dp_q   <= 1'b1;
    end else begin
      an_q   <= an_next;
      sseg_q <= seg_next;
      dp_q   <= dp_next;
    end
  end

  assign bus.an   = an_q;
  assign bus.sseg = sseg_q;
  assign bus.dp   = dp_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_sseg_bcd_scan.sv
// Directed bench for sseg_bcd_scan: two instances (LZB=1 and LZB=0) in lockstep,
// table-driven display vectors plus reset, scan-timing, mid-conversion and reset-abort sequences.
module tb_sseg_bcd_scan;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SB = 7'b1111111, SD = 7'b0111111;

  typedef struct {
    logic [13:0]     value;
    logic [3:0]      dp_in;
    logic [3:0][6:0] seg;     // LZB=1 expectation, index = digit
    logic [3:0][6:0] seg_nz;  // LZB=0 expectation
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  sseg_bcd_scan_if #(.DIGITS(4), .VAL_W(14)) ifa ();
  sseg_bcd_scan_if #(.DIGITS(4), .VAL_W(14)) ifb ();

  sseg_bcd_scan #(.DIGITS(4), .VAL_W(14), .DIV_W(2), .LZB(1)
`ifdef SSEG_BLINK_EN
    , .BLINK_W(3)
`endif
  ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

  sseg_bcd_scan #(.DIGITS(4), .VAL_W(14), .DIV_W(2), .LZB(0)
`ifdef SSEG_BLINK_EN
    , .BLINK_W(3)
`endif
  ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [13:0] v, input logic [3:0] d);
    ifa.value = v;
    ifb.value = v;
    ifa.dp_in = d;
    ifb.dp_in = d;
  endtask

  task automatic wait_an(input logic [3:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifa.an == target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_vec(input vec_t v, input int n);
    bit         ok;
    logic [3:0] tgt;
    set_in(v.value, v.dp_in);
    repeat (40) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      tgt = ~(4'b0001 << k);
      wait_an(tgt, ok);
      check($sformatf("v%0d_d%0d_found", n, k), {31'd0, ok}, 32'd1);
      if (ok) begin
        check($sformatf("v%0d_d%0d_sseg", n, k), {25'd0, ifa.sseg}, {25'd0, v.seg[k]});
        check($sformatf("v%0d_d%0d_dp", n, k), {31'd0, ifa.dp}, {31'd0, ~v.dp_in[k]});
        check($sformatf("v%0d_d%0d_an_nz", n, k), {28'd0, ifb.an}, {28'd0, tgt});
        check($sformatf("v%0d_d%0d_sseg_nz", n, k), {25'd0, ifb.sseg}, {25'd0, v.seg_nz[k]});
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t            vecs[10];
    vec_t            v5678;
    vec_t            v1234;
    int              busy_cnt;
    logic            busy_first;
    logic [3:0]      a0;
    bit              changed;
    int              k0, errs, kk, bad, first_b, last_a;
    bit              seen_a;
    logic [3:0][6:0] p_old, p_a, p_b;

    vecs[0] = '{14'd0,     4'b0000, {SB, SB, SB, S0}, {S0, S0, S0, S0}};
    vecs[1] = '{14'd1234,  4'b0000, {S1, S2, S3, S4}, {S1, S2, S3, S4}};
    vecs[2] = '{14'd9999,  4'b0000, {S9, S9, S9, S9}, {S9, S9, S9, S9}};
    vecs[3] = '{14'd10000, 4'b1010, {SD, SD, SD, SD}, {SD, SD, SD, SD}};
    vecs[4] = '{14'd7,     4'b0100, {SB, SB, SB, S7}, {S0, S0, S0, S7}};
    vecs[5] = '{14'd100,   4'b0001, {SB, S1, S0, S0}, {S0, S1, S0, S0}};
    vecs[6] = '{14'd16383, 4'b1111, {SD, SD, SD, SD}, {SD, SD, SD, SD}};
    vecs[7] = '{14'd1005,  4'b0010, {S1, S0, S0, S5}, {S1, S0, S0, S5}};
    vecs[8] = '{14'd0,     4'b1000, {SB, SB, SB, S0}, {S0, S0, S0, S0}};
    vecs[9] = '{14'd40,    4'b0000, {SB, SB, S4, S0}, {S0, S0, S4, S0}};
    v5678   = '{14'd5678,  4'b0000, {S5, S6, S7, S8}, {S5, S6, S7, S8}};
    v1234   = '{14'd1234,  4'b0000, {S1, S2, S3, S4}, {S1, S2, S3, S4}};

    set_in(14'd0, 4'b0000);
`ifdef SSEG_BLINK_EN
    ifa.blink_mask = 4'b0000;
    ifb.blink_mask = 4'b0000;
`endif

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_an", {28'd0, ifa.an}, 32'hF);
    check("rst_sseg", {25'd0, ifa.sseg}, 32'h7F);
    check("rst_dp", {31'd0, ifa.dp}, 32'd1);
    check("rst_busy", {31'd0, ifa.busy}, 32'd0);

    // forced conversion after reset: busy one cycle later, for VAL_W cycles
    rst = 1'b0;
    busy_cnt = 0;
    @(negedge clk);
    busy_first = ifa.busy;
    if (ifa.busy) busy_cnt++;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (ifa.busy) busy_cnt++;
    end
    check("busy_first", {31'd0, busy_first}, 32'd1);
    check("busy_len", busy_cnt, 14);

    // no reconversion while value is unchanged
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ifa.busy) busy_cnt++;
    end
    check("busy_idle", busy_cnt, 0);

    // scan order and 4-cycle dwell
    a0 = ifa.an;
    changed = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifa.an != a0) begin
        changed = 1'b1;
        break;
      end
    end
    check("scan_change", {31'd0, changed}, 32'd1);
    k0 = 0;
    for (int k = 0; k < 4; k++) if (ifa.an == ~(4'b0001 << k)) k0 = k;
    errs = 0;
    for (int i = 0; i < 32; i++) begin
      if (ifa.an !== ~(4'b0001 << ((k0 + i / 4) % 4))) errs++;
      @(negedge clk);
    end
    check("scan_seq", errs, 0);

    for (int n = 0; n < 10; n++) check_vec(vecs[n], n);

    // value changed mid-conversion: 1234 first, then 5678, never a mix
    p_old = {SB, SB, S4, S0};
    p_a   = {S1, S2, S3, S4};
    p_b   = {S5, S6, S7, S8};
    set_in(14'd1234, 4'b0000);
    bad = 0; first_b = -1; last_a = -1; seen_a = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (i == 5) set_in(14'd5678, 4'b0000);
      kk = -1;
      for (int k = 0; k < 4; k++) if (ifa.an == ~(4'b0001 << k)) kk = k;
      if (kk < 0) bad++;
      else if (ifa.sseg == p_a[kk]) begin
        seen_a = 1'b1;
        last_a = i;
      end else if (ifa.sseg == p_b[kk]) begin
        if (first_b < 0) first_b = i;
      end else if (ifa.sseg != p_old[kk]) bad++;
    end
    check("mid_no_mix", bad, 0);
    check("mid_seen_1234", {31'd0, seen_a}, 32'd1);
    check("mid_seen_5678", {31'd0, (first_b > 0)}, 32'd1);
    check("mid_order", {31'd0, (last_a < first_b)}, 32'd1);
    check("mid_5678_latency", {31'd0, (first_b - 5 <= 32)}, 32'd1);
    check_vec(v5678, 10);

    // reset during conversion: display cleared, fresh conversion afterwards
    set_in(14'd1234, 4'b0000);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstconv_an", {28'd0, ifa.an}, 32'hE);
    check("rstconv_sseg", {25'd0, ifa.sseg}, {25'd0, S0});
    check("rstconv_sseg_nz", {25'd0, ifb.sseg}, {25'd0, S0});
    check("rstconv_busy", {31'd0, ifa.busy}, 32'd1);
    check_vec(v1234, 11);

`ifdef SSEG_BLINK_EN
    // blink counter MSB is high exactly while idx 1 and 3 are scanned
    ifa.blink_mask = 4'b0010;
    errs = 0; busy_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ifa.an == 4'b1101) errs++;
      if (ifa.an == 4'b1111) busy_cnt++;
    end
    check("blink_d1_off", errs, 0);
    check("blink_all_off", busy_cnt, 16);
    ifa.blink_mask = 4'b0001;
    repeat (2) @(negedge clk);
    errs = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ifa.an == 4'b1110) errs++;
    end
    check("blink_d0_shown", errs, 16);
    ifa.blink_mask = 4'b0000;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
